// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and default sizing for the register-file dump reader.
package regfile_dump_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    SEND_A,
    SEND_B,
    FIN
  } state_t;

  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks the register file one even/odd pair at a time and streams each word with its index.
// 4 cycles per pair with the sink always ready; holds the word stable while out_ready is low.
module regfile_dump_reader
  import regfile_dump_reader_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rs1,
  output logic [ADDR_W-1:0] rf_rs2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              rf_wr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index
);

  localparam int          P_W    = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [P_W-1:0] LAST_P = P_W'(NUM_REGS / 2 - 1);

  state_t             state, state_nxt;
  logic [P_W-1:0]     p;
  logic [DATA_W-1:0]  buf_a, buf_b;
  logic [ADDR_W-1:0]  even_idx, odd_idx;

  assign even_idx = ADDR_W'({p, 1'b0});
  assign odd_idx  = ADDR_W'({p, 1'b1});

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p     <= '0;
      buf_a <= '0;
      buf_b <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE:    if (start) p <= '0;
        // Both words come from the same read edge, so the pair is coherent.
        CAPTURE: begin
          buf_a <= rf_data1;
          buf_b <= rf_data2;
        end
        SEND_B:  if (out_ready && (p != LAST_P)) p <= p + P_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    rf_rs1    = even_idx;
    rf_rs2    = odd_idx;
    case (state)
      IDLE: begin
        rf_rs1 = '0;
        rf_rs2 = ADDR_W'(1);
        if (start) state_nxt = ISSUE;
      end
      // A write at this edge zeroes the read data, so retry until a clean read.
      ISSUE: begin
        busy = 1'b1;
        if (!rf_wr) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = SEND_A;
      end
      SEND_A: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_a;
        out_index = even_idx;
        if (out_ready) state_nxt = SEND_B;
      end
      SEND_B: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_b;
        out_index = odd_idx;
        if (out_ready) state_nxt = (p == LAST_P) ? FIN : ISSUE;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: behavioural register file plus scenario table and corner sequences.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, rf_wr, out_valid, out_ready;
  logic [4:0]  rf_rs1, rf_rs2, out_index;
  logic [31:0] rf_data1, rf_data2, out_data;

  logic [31:0] mem [32];
  logic        preload;
  logic [4:0]  wa;
  logic [31:0] wd;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int          low_pct;
    int          trig;
    int          wr_n;
    logic [4:0]  wr_a;
    logic [31:0] wr_d;
    int          delay_from;
    int          delay;
    bit          extra_starts;
    bit          timed;
    bit          chain;
  } vec_t;

  vec_t vecs [4];

  always #5 clk = ~clk;

  regfile_dump_reader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_wr(rf_wr), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index)
  );

  // Registered-read register file; a write edge returns zeros on both ports.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
    end else if (rf_wr) begin
      mem[wa]  <= wd;
      rf_data1 <= '0;
      rf_data2 <= '0;
    end else begin
      rf_data1 <= mem[rf_rs1];
      rf_data2 <= mem[rf_rs2];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_dump(input vec_t v);
    logic [31:0] expd [32];
    int          got_n, ndone, done_cyc, wr_left, cyc, post;
    bit          prev_stall;
    logic [4:0]  prev_idx;
    logic [31:0] prev_dat;
    got_n = 0; ndone = 0; done_cyc = -1; wr_left = 0; cyc = 0; post = 0;
    prev_stall = 1'b0; prev_idx = '0; prev_dat = '0;
    for (int i = 0; i < 32; i++) expd[i] = 32'hA000_0000 + 32'(i);
    if (v.trig >= 0) expd[v.wr_a] = v.wr_d;

    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
    start = 1'b1;
    @(posedge clk);
    while (1) begin
      @(negedge clk);
      start = v.extra_starts && (ndone == 0) && (cyc % 5 == 3);
      if (wr_left > 0) begin
        rf_wr = 1'b1; wa = v.wr_a; wd = v.wr_d; wr_left--;
      end else begin
        rf_wr = 1'b0;
      end
      if (cyc == 0) check("busy_after_start", busy, 1);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_word", {out_index, out_data}, {prev_idx, prev_dat});
      end
      out_ready = ($urandom_range(99) >= v.low_pct);
      if (out_valid) check("rd_addr_pair", {rf_rs1, rf_rs2}, {out_index & 5'h1E, out_index | 5'h01});
      if (out_valid && out_ready) begin
        if (got_n < 32) begin
          check("word_index", out_index, got_n);
          check("word_data", out_data, expd[got_n]);
          if (v.timed)
            check("word_edge", cyc + 1, 4 * (got_n / 2) + 3 + (got_n % 2) +
                                         ((got_n >= v.delay_from) ? v.delay : 0));
        end
        if (got_n == v.trig) wr_left = v.wr_n;
        got_n++;
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_index;
      prev_dat   = out_data;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      if (ndone > 0) begin
        post++;
        if (v.chain) begin
          if (post == 1) start = 1'b1;
          if (post == 2) begin
            check("fin_start_ignored", busy, 0);
            start = 1'b1;
          end
          if (post == 3) begin
            check("start_after_done", busy, 1);
            break;
          end
        end
      end
      if (post > 3 || cyc > 2000) break;
      @(posedge clk);
      cyc++;
    end
    rf_wr = 1'b0;
    out_ready = 1'b1;
    if (!v.chain) start = 1'b0;
    check("word_count", got_n, 32);
    check("done_count", ndone, 1);
    if (v.timed) check("done_cycle", done_cyc, 64 + v.delay);
  endtask

  initial begin
    int  n;
    bit  saw_done;
    rst = 1'b1; start = 1'b0; rf_wr = 1'b0; out_ready = 1'b1;
    preload = 1'b0; wa = '0; wd = '0;

    //            low  trig n  wr_a   wr_d           dfrom dly xs tm ch
    vecs[0] = '{  0,  -1,  0, 5'd0,  32'h0,          99,  0,  0, 1, 0};
    vecs[1] = '{  0,   9,  3, 5'd31, 32'hA000_001F,  10,  3,  0, 1, 0};
    vecs[2] = '{ 30,  -1,  0, 5'd0,  32'h0,          99,  0,  1, 0, 0};
    vecs[3] = '{  0,   2,  1, 5'd4,  32'hDEAD_BEEF,  99,  0,  0, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    check("rst_rs1", rf_rs1, 0);
    check("rst_rs2", rf_rs2, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) run_dump(vecs[k]);

    // The chained dump is now running; abort it in SEND_B of pair 7.
    start = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (!(out_valid && out_index == 5'd15) && n < 200) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("reach_pair7_send_b", out_valid && out_index == 5'd15, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("no_done_after_abort", saw_done, 0);

    run_dump(vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/verification reader that walks the whole register file and streams every register out as an indexed word stream.
- Drives the register file read ports (rs1/rs2) and captures ruRs1/ruRs2. It reads an even/odd register pair per access.
- Sits beside the single-cycle datapath and shares the read ports via an external mux while busy=1.
- Sink side is a valid/ready stream toward a trace/UART/bench monitor.

Parameters:
- NUM_REGS, 32, number of registers to dump; must be even and ≥2.
- ADDR_W, 5, register index width; must satisfy 2**ADDR_W ≥ NUM_REGS.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begin a dump. Ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until the final word handshakes.
- done  out  1  one-cycle pulse in the cycle after the last word handshakes.
- rf_rs1  out  ADDR_W  read address to register file port 1 (even index).
- rf_rs2  out  ADDR_W  read address to register file port 2 (odd index).
- rf_data1  in  DATA_W  register file ruRs1.
- rf_data2  in  DATA_W  register file ruRs2.
- rf_wr  in  1  copy of the register file write enable (ruWr).
- out_valid  out  1  stream word valid.
- out_ready  in  1  sink ready.
- out_data  out  DATA_W  register contents.
- out_index  out  ADDR_W  register index of out_data.

Behaviour:
- Register-file timing contract:
  - Reads are registered: the address presented in cycle t appears on rf_data in cycle t+1.
  - Exception: if rf_wr=1 at the t→t+1 edge, the register file outputs 0 instead of the data. That read is invalid.
- Reset (rst=1 at a clock edge) forces:
  - state IDLE, pair counter=0;
  - busy=0, done=0, out_valid=0;
  - out_data=0, out_index=0, rf_rs1=0, rf_rs2=1.
- Reset mid-dump aborts immediately. No partial done is produced.
- FSM states:
  - IDLE: rf_rs1=0, rf_rs2=1. If start=1, clear pair counter p and go to ISSUE.
  - ISSUE: rf_rs1=2p, rf_rs2=2p+1.
    - If rf_wr=0 this cycle, go to CAPTURE.
    - If rf_wr=1, stay in ISSUE (retry). Retries are unbounded; the block stalls while rf_wr is held high.
  - CAPTURE: latch rf_data1 into buf_a and rf_data2 into buf_b. Go to SEND_A. Addresses stay held.
  - SEND_A: out_valid=1, out_data=buf_a, out_index=2p. On out_ready=1, go to SEND_B.
  - SEND_B: out_valid=1, out_data=buf_b, out_index=2p+1. On out_ready=1:
    - if p=NUM_REGS/2−1, go to FIN;
    - otherwise p++ and go to ISSUE.
  - FIN: done=1 for one cycle, busy=0, then IDLE.
- Stream rules:
  - While out_valid=1 and out_ready=0, out_data and out_index stay stable. out_valid never drops without a handshake.
  - The handshake occurs in a cycle with out_valid & out_ready both high.
- busy=1 in ISSUE, CAPTURE, SEND_A and SEND_B; 0 in IDLE and FIN.
- Best-case latency: start at edge 0 → first out_valid 3 cycles later.
  - Each pair costs 4 cycles with out_ready tied high.
  - A full 32-register dump takes 64 cycles after start.
- Consistency: there is no snapshot guarantee across pairs. A write between pairs is visible in later pairs. Within a pair, both words come from the same read edge.
- Counter width is ADDR_W−1 bits; p must not wrap past NUM_REGS/2−1.

Decomposition:
- Shared package: state enum (IDLE, ISSUE, CAPTURE, SEND_A, SEND_B, FIN) and the default NUM_REGS/ADDR_W/DATA_W constants used by registers_unit.
- No sub-module. Single FSM with counter and two capture buffers.

Test Plan:
- Preload x[i]=0xA000_0000+i and hold out_ready=1, then start → 32 words in order, index 0..31, data 0xA000_0000..0xA000_001F. Done pulses once, 64 cycles after start.
- Assert rf_wr=1 for 3 cycles while in ISSUE for pair 5 → no zero words emitted. Words 10/11 carry the correct values and appear 3 cycles later than nominal.
- Random out_ready with a 30% low rate → out_data/out_index stable while stalled. Sequence and count are unchanged.
- Start pulses while busy=1 → ignored, with exactly one done. Start in the same cycle as FIN → ignored. Start one cycle after done → new dump.
- Assert rst during SEND_B of pair 7 → next cycle busy=0, out_valid=0, no done. A subsequent start restarts at index 0.
- Write x4=0xDEAD_BEEF between pair 1 and pair 2 → word index 4 equals 0xDEAD_BEEF.
